// File: rtl/spec_dpram_reader_pkg.sv
// Shared spectrum definitions: readout FSM encoding and default frame geometry.
package spec_dpram_reader_pkg;

    localparam int unsigned DEF_ADDR_W    = 14;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_NOF_WORDS = 16384; // 16 range bins x 1024 points

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/spec_dpram_reader_if.sv
// DPRAM port-B read bus, output word stream and frame control of the spectrum reader.
interface spec_dpram_reader_if
    import spec_dpram_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              start_i;
    logic [ADDR_W-1:0] rdaddr_o;
    logic [DATA_W-1:0] rddata_i;
    logic [15:0]       y_hi_o;
    logic [15:0]       y_lo_o;
    logic              data_valid_o;
    logic              ready_i;
    logic              busy_o;
    logic              done_o;
    logic              start_err_o;

    modport master (
        input  start_i, rddata_i, ready_i,
        output rdaddr_o, y_hi_o, y_lo_o, data_valid_o, busy_o, done_o, start_err_o
    );

    modport slave (
        output start_i, rddata_i, ready_i,
        input  rdaddr_o, y_hi_o, y_lo_o, data_valid_o, busy_o, done_o, start_err_o
    );
endinterface

// File: rtl/spec_out_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module spec_out_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && (cnt_q != CNT_W'(DEPTH));
        do_pop   = pop_i && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

// File: rtl/spec_dpram_reader.sv
// Streams one accumulated-spectrum frame out of DPRAM port B through a small
// output FIFO with ready/valid back-pressure.
module spec_dpram_reader
    import spec_dpram_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NOF_WORDS  = DEF_NOF_WORDS,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    spec_dpram_reader_if.master bus
);
    localparam int unsigned     CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NOF_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
    logic [ADDR_W-1:0] xfer_q, xfer_d;
    logic              rd_q, rd_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              pop;
    logic              room;

    // rd_q marks a read presented on rdaddr_o this cycle; vld_q marks its data on
    // rddata_i one cycle later. Both count against FIFO space so a push can never overflow.
    always_comb begin
        pop      = !fifo_empty && bus.ready_i;
        room     = (32'(fifo_count) + 32'(rd_q) + 32'(vld_q)) < FIFO_DEPTH;
        state_d  = state_q;
        rdaddr_d = rdaddr_q;
        xfer_d   = xfer_q;
        rd_d     = 1'b0;
        vld_d    = rd_q;
        err_d    = err_q;
        if (pop) xfer_d = xfer_q + ADDR_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    rdaddr_d = '0;
                    xfer_d   = '0;
                    rd_d     = 1'b1;
                    state_d  = (LAST_ADDR == '0) ? ST_DRAIN : ST_READ;
                end
            end
            ST_READ: begin
                if (bus.start_i) err_d = 1'b1;
                if (room) begin
                    rd_d     = 1'b1;
                    rdaddr_d = rdaddr_q + ADDR_W'(1);
                    if (rdaddr_d == LAST_ADDR) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.start_i) err_d = 1'b1;
                if (pop && (xfer_q == LAST_ADDR)) state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rdaddr_q <= '0;
            xfer_q   <= '0;
            rd_q     <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdaddr_q <= rdaddr_d;
            xfer_q   <= xfer_d;
            rd_q     <= rd_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    spec_out_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (vld_q),
        .data_i  (bus.rddata_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.rdaddr_o     = rdaddr_q;
    assign bus.data_valid_o = !fifo_empty;
    assign bus.y_hi_o       = fifo_empty ? '0 : fifo_data[31:16];
    assign bus.y_lo_o       = fifo_empty ? '0 : fifo_data[15:0];
    assign bus.busy_o       = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign bus.done_o       = (state_q == ST_FINISH);
    assign bus.start_err_o  = err_q;
endmodule

// File: tb/tb_spec_dpram_reader.sv
// Bench for spec_dpram_reader: a 16-word frame instance for protocol scenarios
// and a full 16384-word instance for the address-boundary frame.
module tb_spec_dpram_reader;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned NA = 16;
    localparam int unsigned NB = 16384;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    spec_dpram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    spec_dpram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    spec_dpram_reader #(.ADDR_W(AW), .DATA_W(DW), .NOF_WORDS(NA), .FIFO_DEPTH(4)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (bus_a)
    );
    spec_dpram_reader #(.ADDR_W(AW), .DATA_W(DW), .NOF_WORDS(NB), .FIFO_DEPTH(4)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (bus_b)
    );

    // DPRAM models: registered read, data one cycle after the address
    always @(posedge clk) bus_a.rddata_i <= DW'(bus_a.rdaddr_o);
    always @(posedge clk) bus_b.rddata_i <= 32'hA5A5_0000 + DW'(bus_b.rdaddr_o);

    // Reference: a frame of n words where word i equals base + i
    function automatic int frame_errs(input logic [31:0] q[$], input int unsigned n, input logic [31:0] base);
        int bad = 0;
        if (q.size() != int'(n)) bad++;
        for (int i = 0; i < q.size(); i++)
            if (q[i] !== base + 32'(i)) bad++;
        return bad;
    endfunction

    logic [31:0] rxa[$];
    int          rxa_t[$];
    int          done_a = 0, done_t_a = 0, stall_err_a = 0;
    logic        stall_a = 1'b0;
    logic [31:0] held_a = '0;
    logic [31:0] rxb[$];
    int          done_b = 0, wrap_b = 0;
    logic [AW-1:0] prev_addr_b = '0;

    always @(negedge clk) begin
        if (rst) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a && (bus_a.data_valid_o !== 1'b1 || {bus_a.y_hi_o, bus_a.y_lo_o} !== held_a))
                stall_err_a++;
            stall_a = bus_a.data_valid_o && !bus_a.ready_i;
            held_a  = {bus_a.y_hi_o, bus_a.y_lo_o};
            if (bus_a.data_valid_o && bus_a.ready_i) begin
                rxa.push_back({bus_a.y_hi_o, bus_a.y_lo_o});
                rxa_t.push_back(cyc);
            end
            if (bus_a.done_o) begin done_a++; done_t_a = cyc; end
            if (bus_b.data_valid_o && bus_b.ready_i) rxb.push_back({bus_b.y_hi_o, bus_b.y_lo_o});
            if (bus_b.done_o) done_b++;
            if (bus_b.busy_o && bus_b.rdaddr_o < prev_addr_b) wrap_b++;
            prev_addr_b = bus_b.busy_o ? bus_b.rdaddr_o : '0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_a();
        rxa.delete(); rxa_t.delete(); done_a = 0; stall_err_a = 0;
    endtask

    // edge_n: number of the clock edge that samples the start pulse
    task automatic start_a(output int edge_n);
        bus_a.start_i = 1'b1; edge_n = cyc + 1; tick(); bus_a.start_i = 1'b0;
    endtask

    task automatic wait_done_a(input int limit);
        for (int k = 0; k < limit && done_a == 0; k++) tick();
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.start_i = 1'b0; bus_a.ready_i = 1'b0;
        bus_b.start_i = 1'b0; bus_b.ready_i = 1'b0;
        tick(2);
        n_total++; if (bus_a.rdaddr_o !== '0) $display("FAIL reset_rdaddr: got %0d want 0", bus_a.rdaddr_o); else n_pass++;
        n_total++; if (bus_a.data_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus_a.data_valid_o); else n_pass++;
        n_total++; if ({bus_a.y_hi_o, bus_a.y_lo_o} !== 32'h0) $display("FAIL reset_y: got %h want 0", {bus_a.y_hi_o, bus_a.y_lo_o}); else n_pass++;
        n_total++; if (bus_a.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus_a.busy_o); else n_pass++;
        n_total++; if (bus_a.done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", bus_a.done_o); else n_pass++;
        n_total++; if (bus_a.start_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", bus_a.start_err_o); else n_pass++;
        n_total++; if (bus_b.rdaddr_o !== '0 || bus_b.data_valid_o !== 1'b0) $display("FAIL reset_b: addr %0d valid %b want 0/0", bus_b.rdaddr_o, bus_b.data_valid_o); else n_pass++;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        int e, last, bad_t;
        clear_a(); bus_a.ready_i = 1'b1;
        start_a(e);
        wait_done_a(100);
        n_total++; if (frame_errs(rxa, NA, 32'h0) != 0) $display("FAIL basic_words: got %0d words, %0d errors, want %0d words in order", rxa.size(), frame_errs(rxa, NA, 32'h0), NA); else n_pass++;
        n_total++; if (rxa_t.size() == 0 || rxa_t[0] != e + 2) $display("FAIL basic_latency: first word at %0d want %0d", (rxa_t.size() != 0) ? rxa_t[0] : -1, e + 2); else n_pass++;
        bad_t = 0;
        for (int i = 0; i < rxa_t.size(); i++) if (rxa_t[i] != e + 2 + i) bad_t++;
        n_total++; if (bad_t != 0) $display("FAIL basic_rate: got %0d off-cycle words want 0", bad_t); else n_pass++;
        last = (rxa_t.size() != 0) ? rxa_t[rxa_t.size() - 1] : -100;
        n_total++; if (done_a != 1 || done_t_a != last + 1) $display("FAIL basic_done: got %0d pulses at %0d want 1 at %0d", done_a, done_t_a, last + 1); else n_pass++;
        n_total++; if (bus_a.busy_o !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", bus_a.busy_o); else n_pass++;
    endtask

    task automatic test_toggle();
        int e;
        clear_a(); bus_a.ready_i = 1'b1;
        start_a(e);
        for (int k = 0; k < 200 && done_a == 0; k++) begin bus_a.ready_i = ~bus_a.ready_i; tick(); end
        bus_a.ready_i = 1'b1; tick(3);
        n_total++; if (frame_errs(rxa, NA, 32'h0) != 0) $display("FAIL toggle_words: got %0d words, %0d errors", rxa.size(), frame_errs(rxa, NA, 32'h0)); else n_pass++;
        n_total++; if (stall_err_a != 0) $display("FAIL toggle_hold: got %0d unstable stall cycles want 0", stall_err_a); else n_pass++;
        n_total++; if (bus_a.start_err_o !== 1'b0) $display("FAIL toggle_err: got %b want 0", bus_a.start_err_o); else n_pass++;
        n_total++; if (done_a != 1) $display("FAIL toggle_done: got %0d pulses want 1", done_a); else n_pass++;
    endtask

    task automatic test_finish_start();
        int e;
        clear_a(); bus_a.ready_i = 1'b1;
        start_a(e);
        for (int k = 0; k < 100 && bus_a.done_o !== 1'b1; k++) tick();
        bus_a.start_i = 1'b1; tick(); bus_a.start_i = 1'b0;
        tick(5);
        n_total++; if (bus_a.start_err_o !== 1'b0) $display("FAIL finish_err: got %b want 0", bus_a.start_err_o); else n_pass++;
        n_total++; if (bus_a.busy_o !== 1'b0 || bus_a.data_valid_o !== 1'b0) $display("FAIL finish_ignored: busy %b valid %b want 0/0", bus_a.busy_o, bus_a.data_valid_o); else n_pass++;
        n_total++; if (done_a != 1 || frame_errs(rxa, NA, 32'h0) != 0) $display("FAIL finish_frame: %0d done, %0d words want 1/%0d", done_a, rxa.size(), NA); else n_pass++;
    endtask

    task automatic test_backpressure();
        int e;
        clear_a(); bus_a.ready_i = 1'b0;
        start_a(e);
        tick(19);
        n_total++; if (bus_a.rdaddr_o !== AW'(3)) $display("FAIL bp_addr: got %0d want 3", bus_a.rdaddr_o); else n_pass++;
        n_total++; if (int'(dut_a.fifo_count) != 4) $display("FAIL bp_count: got %0d want 4", dut_a.fifo_count); else n_pass++;
        n_total++; if (bus_a.data_valid_o !== 1'b1 || {bus_a.y_hi_o, bus_a.y_lo_o} !== 32'h0) $display("FAIL bp_head: valid %b word %h want 1/0", bus_a.data_valid_o, {bus_a.y_hi_o, bus_a.y_lo_o}); else n_pass++;
        bus_a.ready_i = 1'b1;
        wait_done_a(100);
        n_total++; if (frame_errs(rxa, NA, 32'h0) != 0) $display("FAIL bp_words: got %0d words, %0d errors", rxa.size(), frame_errs(rxa, NA, 32'h0)); else n_pass++;
        n_total++; if (done_a != 1) $display("FAIL bp_done: got %0d pulses want 1", done_a); else n_pass++;
    endtask

    task automatic test_random();
        int e, bias;
        for (int f = 0; f < 3; f++) begin
            clear_a(); bias = int'($urandom_range(1, 3));
            bus_a.ready_i = 1'b0; tick(int'($urandom_range(0, 5)));
            start_a(e);
            for (int k = 0; k < 400 && done_a == 0; k++) begin
                bus_a.ready_i = (int'($urandom_range(0, 3)) < bias);
                tick();
            end
            bus_a.ready_i = 1'b1; tick(3);
            n_total++; if (frame_errs(rxa, NA, 32'h0) != 0 || done_a != 1) $display("FAIL random_frame%0d: %0d words, %0d errors, %0d done", f, rxa.size(), frame_errs(rxa, NA, 32'h0), done_a); else n_pass++;
            n_total++; if (stall_err_a != 0) $display("FAIL random_hold%0d: got %0d unstable stall cycles want 0", f, stall_err_a); else n_pass++;
        end
    endtask

    task automatic test_restart_err();
        int e;
        clear_a(); bus_a.ready_i = 1'b1;
        start_a(e);
        for (int k = 0; k < 50 && rxa.size() < 5; k++) tick();
        bus_a.start_i = 1'b1; tick(); bus_a.start_i = 1'b0;
        wait_done_a(100);
        n_total++; if (bus_a.start_err_o !== 1'b1) $display("FAIL restart_err: got %b want 1", bus_a.start_err_o); else n_pass++;
        n_total++; if (frame_errs(rxa, NA, 32'h0) != 0) $display("FAIL restart_words: got %0d words, %0d errors", rxa.size(), frame_errs(rxa, NA, 32'h0)); else n_pass++;
        n_total++; if (done_a != 1) $display("FAIL restart_done: got %0d pulses want 1", done_a); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int e;
        clear_a(); bus_a.ready_i = 1'b1;
        start_a(e);
        for (int k = 0; k < 50 && rxa.size() < 8; k++) tick();
        rst = 1'b1; #1;
        n_total++; if (bus_a.rdaddr_o !== '0 || bus_a.data_valid_o !== 1'b0 || {bus_a.y_hi_o, bus_a.y_lo_o} !== 32'h0) $display("FAIL midrst_out: addr %0d valid %b y %h want 0", bus_a.rdaddr_o, bus_a.data_valid_o, {bus_a.y_hi_o, bus_a.y_lo_o}); else n_pass++;
        n_total++; if (bus_a.busy_o !== 1'b0 || bus_a.done_o !== 1'b0 || bus_a.start_err_o !== 1'b0) $display("FAIL midrst_ctl: busy %b done %b err %b want 0", bus_a.busy_o, bus_a.done_o, bus_a.start_err_o); else n_pass++;
        tick(2); rst = 1'b0; tick(3);
        n_total++; if (done_a != 0) $display("FAIL midrst_nodone: got %0d pulses want 0", done_a); else n_pass++;
        clear_a();
        start_a(e);
        wait_done_a(100);
        n_total++; if (frame_errs(rxa, NA, 32'h0) != 0 || done_a != 1) $display("FAIL midrst_next: %0d words, %0d errors, %0d done", rxa.size(), frame_errs(rxa, NA, 32'h0), done_a); else n_pass++;
    endtask

    task automatic test_full();
        rxb.delete(); done_b = 0; wrap_b = 0;
        bus_b.ready_i = 1'b1;
        bus_b.start_i = 1'b1; tick(); bus_b.start_i = 1'b0;
        for (int k = 0; k < 17000 && done_b == 0; k++) tick();
        tick(3);
        n_total++; if (done_b != 1) $display("FAIL full_done: got %0d pulses want 1", done_b); else n_pass++;
        n_total++; if (frame_errs(rxb, NB, 32'hA5A5_0000) != 0) $display("FAIL full_words: got %0d words, %0d errors want %0d", rxb.size(), frame_errs(rxb, NB, 32'hA5A5_0000), NB); else n_pass++;
        n_total++; if (rxb.size() == 0 || rxb[rxb.size() - 1] !== 32'hA5A5_3FFF) $display("FAIL full_last: got %h want a5a53fff", (rxb.size() != 0) ? rxb[rxb.size() - 1] : 32'h0); else n_pass++;
        n_total++; if (wrap_b != 0 || bus_b.rdaddr_o !== AW'(NB - 1)) $display("FAIL full_addr: %0d wraps, final addr %0d want 0/%0d", wrap_b, bus_b.rdaddr_o, NB - 1); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_finish_start();
        test_backpressure();
        test_random();
        test_restart_err();
        test_reset_mid();
        test_full();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spec_dpram_reader.md
SPEC_DPRAM_READER -- requirements
Module: spec_dpram_reader

Interface
REQ-001 Parameter ADDR_W, default 14, DPRAM port-B address width.
REQ-002 Parameter DATA_W, default 32, accumulated-spectrum word width.
REQ-003 Parameter NOF_WORDS, default 16384 (16 range bins x 1024 points), words per readout frame; SHALL be in the range 1..2^ADDR_W.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries; SHALL be a power of two and at least 4.
REQ-005 clk_i  in  1  clock; all logic SHALL be on its rising edge.
REQ-006 rst_i  in  1  reset; asynchronous, active-high.
REQ-007 start_i  in  1  one-cycle pulse; accumulation of all range bins is complete and a frame readout begins.
REQ-008 rdaddr_o  out  ADDR_W  DPRAM port-B read address.
REQ-009 rddata_i  in  DATA_W  DPRAM port-B data; valid exactly 1 cycle after the address is presented.
REQ-010 y_hi_o  out  16  output word bits [31:16].
REQ-011 y_lo_o  out  16  output word bits [15:0].
REQ-012 data_valid_o  out  1  y_hi_o/y_lo_o carry a valid word this cycle.
REQ-013 ready_i  in  1  downstream accepts; a word transfers on a cycle with data_valid_o=1 and ready_i=1.
REQ-014 busy_o  out  1  high from the cycle after an accepted start_i until the last word transfers.
REQ-015 done_o  out  1  one-cycle pulse in the cycle after the last word transfers.
REQ-016 start_err_o  out  1  sticky flag: start_i arrived while busy_o=1; cleared only by reset.

Function
REQ-017 FSM states: IDLE, READ, DRAIN, FINISH.
REQ-018 IDLE->READ on start_i=1; the read address counter SHALL load 0 and the transferred-word counter SHALL load 0.
REQ-019 In READ, one read SHALL be issued per cycle while (FIFO count + reads in flight) < FIFO_DEPTH; rdaddr_o SHALL increment by 1 per issued read.
REQ-020 READ->DRAIN in the cycle the read of address NOF_WORDS-1 is issued; in DRAIN, no further reads are issued.
REQ-021 DRAIN->FINISH on transfer of word number NOF_WORDS-1; FINISH asserts done_o for 1 cycle, then returns to IDLE.
REQ-022 Each rddata_i word SHALL be pushed into the FIFO the cycle after its read; the FIFO SHALL never overflow.
REQ-023 data_valid_o SHALL equal FIFO not-empty; outputs SHALL hold their value while data_valid_o=1 and ready_i=0.
REQ-024 Latency with ready_i held high: start_i at edge N -> first read at edge N+1 -> first word in the FIFO at edge N+2 -> data_valid_o=1 after edge N+2; throughput 1 word/cycle; the frame spans NOF_WORDS+2 cycles.
REQ-025 Word order SHALL be ascending address, with no repeats or gaps; y_hi_o/y_lo_o SHALL be the unmodified split of the DATA_W word.
REQ-026 start_i while busy_o=1 SHALL be ignored and SHALL set start_err_o.
REQ-027 start_i in the FINISH cycle SHALL be ignored without setting start_err_o.
REQ-028 When NOF_WORDS=2^ADDR_W, the address counter SHALL stop at all-ones and SHALL NOT wrap to issue an extra read.
REQ-029 rdaddr_o SHALL hold its last value when no read is issued.

Reset
REQ-030 On rst_i: state IDLE, rdaddr_o=0, FIFO empty, data_valid_o=0, y_hi_o=0, y_lo_o=0, busy_o=0, done_o=0, start_err_o=0.
REQ-031 Reset mid-frame SHALL abandon the frame immediately; no partial done_o pulse.
REQ-032 After reset, the next start_i SHALL begin a full frame from address 0.

Structure
REQ-033 The FSM state encoding and the defaults for ADDR_W, DATA_W and NOF_WORDS belong in the shared spectrum package, together with the accumulator.
REQ-034 One sub-module: spec_out_fifo, a synchronous first-word-fall-through FIFO with push, pop and count.

Verification
REQ-035 NOF_WORDS=16, RAM content = address, ready_i=1, start_i pulse -> words 0..15 on consecutive cycles, first word 2 cycles after start_i, done_o 1 cycle after word 15.
REQ-036 Same setup, ready_i toggling 1/0 every cycle -> 16 words in order with no loss or duplication, y_hi_o/y_lo_o stable while stalled, start_err_o=0.
REQ-037 ready_i=0 for 20 cycles after start_i -> FIFO count caps at 4, rdaddr_o stops at 3; on release, words 0..15 are delivered in order.
REQ-038 start_i again at word 5 -> start_err_o=1, the frame continues unchanged, one done_o pulse.
REQ-039 rst_i asserted at word 8 -> all outputs reach reset values at once, no done_o; the next start_i yields words 0..15.
REQ-040 NOF_WORDS=16384, RAM content = 32'hA5A50000+address -> 16384 words, last word y_hi_o=16'hA5A5, y_lo_o=16'h3FFF, and no read issued beyond address 16383.
